// File: rtl/washer_pkg.sv
// Shared types and constants for the washer sequencer and its phase timer.
package washer_pkg;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_RINSE = 3'd3,
        PH_SPIN  = 3'd4,
        PH_DONE  = 3'd5,
        PH_FAULT = 3'd7
    } phase_e;

    localparam int unsigned DEF_DONE_HOLD  = 4;
    localparam logic [31:0] DEF_WDOG_LIMIT = 32'd1_000_000_000;

    // Timer clk_freq selector codes; the timer decodes the same values.
    localparam logic [1:0] CLK_FREQ_1KHZ  = 2'd0;
    localparam logic [1:0] CLK_FREQ_1MHZ  = 2'd1;
    localparam logic [1:0] CLK_FREQ_50MHZ = 2'd2;
    localparam logic [1:0] CLK_FREQ_100MHZ = 2'd3;

    function automatic logic is_active(input phase_e p);
        return (p == PH_FILL) || (p == PH_WASH) || (p == PH_RINSE) || (p == PH_SPIN);
    endfunction

endpackage

// File: rtl/washer_wdog.sv
// Per-phase watchdog: counts enabled cycles and flags the cycle that reaches the limit.
module washer_wdog (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] limit,
    output logic        expired
);

    logic [31:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            r_cnt <= 32'd0;
        else if (en)
            r_cnt <= r_cnt + 32'd1;
    end

    // Asserted during the enabled cycle that completes the limit-th count.
    assign expired = en && (r_cnt >= (limit - 32'd1));

endmodule

// File: rtl/washer_ctrl.sv
// Washing-machine sequencer: coin start, fill/wash/rinse/spin stepping on timer
// finish, pause gating, completion counting and watchdog fault trap.
module washer_ctrl
    import washer_pkg::*;
#(
    parameter int unsigned DONE_HOLD  = DEF_DONE_HOLD,
    parameter logic [31:0] WDOG_LIMIT = DEF_WDOG_LIMIT,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin_in,
    input  logic             double_wash,
    input  logic             pause_req,
    input  logic             timer_finish,
    output logic             state_time,
    output logic             timer_pause,
    output logic             double_time,
    output logic [2:0]       phase,
    output logic             valve_on,
    output logic             motor_on,
    output logic             spin_fast,
    output logic             door_lock,
    output logic             wash_done,
    output logic             fault,
    output logic [CNT_W-1:0] wash_count
);

    localparam logic [31:0] HOLD_LAST = 32'(DONE_HOLD - 1);

    phase_e           r_state;
    logic             r_coin_prev;
    logic             r_double;
    logic             r_rinse_pass;
    logic [31:0]      r_hold;
    logic             r_st;
    logic             r_pause;
    logic             r_valve;
    logic             r_motor;
    logic             r_spin;
    logic             r_lock;
    logic             r_done;
    logic             r_fault;
    logic [CNT_W-1:0] r_count;

    phase_e w_next;
    logic   w_coin_edge;
    logic   w_wdog_exp;
    logic   w_wdog_clr;
    logic   w_wdog_en;
    logic   w_paused_next;
    logic   w_start;

    assign w_coin_edge = coin_in && !r_coin_prev;
    assign w_start     = (r_state == PH_IDLE) && (w_next == PH_FILL);
    assign w_wdog_clr  = (w_next != r_state);
    assign w_wdog_en   = is_active(r_state) && !r_pause;

    washer_wdog u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_wdog_clr),
        .en      (w_wdog_en),
        .limit   (WDOG_LIMIT),
        .expired (w_wdog_exp)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            PH_IDLE:  if (w_coin_edge) w_next = PH_FILL;
            PH_FILL:  if (timer_finish) w_next = PH_WASH;
            PH_WASH:  if (timer_finish) w_next = PH_RINSE;
            PH_RINSE: if (timer_finish) w_next = (r_double && !r_rinse_pass) ? PH_WASH : PH_SPIN;
            PH_SPIN:  if (timer_finish) w_next = PH_DONE;
            PH_DONE:  if (r_hold == HOLD_LAST) w_next = PH_IDLE;
            PH_FAULT: w_next = PH_FAULT;
            default:  w_next = PH_IDLE;
        endcase
        // A finish in the same cycle as expiry wins; the phase change clears the dog.
        if (is_active(r_state) && !timer_finish && w_wdog_exp)
            w_next = PH_FAULT;
    end

    assign w_paused_next = (w_next == PH_FAULT) || (pause_req && is_active(w_next));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= PH_IDLE;
            r_coin_prev  <= 1'b0;
            r_double     <= 1'b0;
            r_rinse_pass <= 1'b0;
            r_hold       <= 32'd0;
            r_st         <= 1'b0;
            r_pause      <= 1'b0;
            r_valve      <= 1'b0;
            r_motor      <= 1'b0;
            r_spin       <= 1'b0;
            r_lock       <= 1'b0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
            r_count      <= '0;
        end else begin
            r_state     <= w_next;
            r_coin_prev <= coin_in;
            if (w_start) begin
                r_double     <= double_wash;
                r_rinse_pass <= 1'b0;
            end else if (r_state == PH_RINSE && w_next == PH_WASH) begin
                r_rinse_pass <= 1'b1;
            end else if (w_next == PH_IDLE) begin
                r_double <= 1'b0;
            end
            r_hold  <= (r_state == PH_DONE) ? r_hold + 32'd1 : 32'd0;
            r_st    <= w_start;
            r_pause <= w_paused_next;
            r_valve <= !w_paused_next && (w_next == PH_FILL);
            r_motor <= !w_paused_next && ((w_next == PH_WASH) || (w_next == PH_RINSE) ||
                                          (w_next == PH_SPIN));
            r_spin  <= !w_paused_next && (w_next == PH_SPIN);
            r_lock  <= (w_next != PH_IDLE);
            r_fault <= (w_next == PH_FAULT);
            r_done  <= (r_state == PH_DONE) && (w_next == PH_IDLE);
            if ((r_state == PH_DONE) && (w_next == PH_IDLE) && (r_count != '1))
                r_count <= r_count + 1'b1;
        end
    end

    assign phase       = r_state;
    assign state_time  = r_st;
    assign timer_pause = r_pause;
    assign double_time = r_double;
    assign valve_on    = r_valve;
    assign motor_on    = r_motor;
    assign spin_fast   = r_spin;
    assign door_lock   = r_lock;
    assign wash_done   = r_done;
    assign fault       = r_fault;
    assign wash_count  = r_count;

endmodule

// File: tb/tb_washer_ctrl.sv
// Directed bench for washer_ctrl: normal, double, pause, saturation, reset and watchdog runs.
module tb_washer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_in;
    logic       double_wash;
    logic       pause_req;
    logic       timer_finish;
    logic       state_time;
    logic       timer_pause;
    logic       double_time;
    logic [2:0] phase;
    logic       valve_on;
    logic       motor_on;
    logic       spin_fast;
    logic       door_lock;
    logic       wash_done;
    logic       fault;
    logic [1:0] wash_count;

    int n_cmp = 0;
    int n_err = 0;
    int st_cnt = 0;
    int st_base;

    always #5 clk = ~clk;

    washer_ctrl #(
        .DONE_HOLD  (4),
        .WDOG_LIMIT (32'd50),
        .CNT_W      (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_in      (coin_in),
        .double_wash  (double_wash),
        .pause_req    (pause_req),
        .timer_finish (timer_finish),
        .state_time   (state_time),
        .timer_pause  (timer_pause),
        .double_time  (double_time),
        .phase        (phase),
        .valve_on     (valve_on),
        .motor_on     (motor_on),
        .spin_fast    (spin_fast),
        .door_lock    (door_lock),
        .wash_done    (wash_done),
        .fault        (fault),
        .wash_count   (wash_count)
    );

    always @(negedge clk) if (state_time) st_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic dw);
        coin_in = 1'b1; double_wash = dw;
        cyc();
        chk("start_phase", phase, 1);
        chk("start_pulse", state_time, 1);
        coin_in = 1'b0; double_wash = 1'b0;
        cyc();
        chk("start_pulse_1cyc", state_time, 0);
    endtask

    task automatic adv(input logic [2:0] exp);
        repeat (8) cyc();
        timer_finish = 1'b1;
        cyc();
        timer_finish = 1'b0;
        chk("adv_phase", phase, exp);
    endtask

    task automatic finish_done(input logic [1:0] exp_cnt);
        repeat (3) cyc();
        chk("done_hold", phase, 5);
        cyc();
        chk("done_to_idle", phase, 0);
        chk("wash_done", wash_done, 1);
        chk("wash_count", wash_count, exp_cnt);
        cyc();
        chk("wash_done_1cyc", wash_done, 0);
    endtask

    initial begin
        rst = 1'b1; coin_in = 1'b0; double_wash = 1'b0; pause_req = 1'b0; timer_finish = 1'b0;
        cyc(); cyc();
        chk("rst_phase", phase, 0);
        chk("rst_outs", {state_time, timer_pause, double_time, valve_on, motor_on,
                         spin_fast, door_lock, wash_done, fault}, 0);
        chk("rst_count", wash_count, 0);
        rst = 1'b0;
        cyc();

        // single wash
        st_base = st_cnt;
        start(1'b0);
        chk("fill_valve", valve_on, 1);
        chk("fill_lock", door_lock, 1);
        adv(3'd2);
        chk("wash_motor", {valve_on, motor_on}, 2'b01);
        adv(3'd3);
        adv(3'd4);
        chk("spin_fast", {motor_on, spin_fast}, 2'b11);
        adv(3'd5);
        chk("done_acts", {door_lock, motor_on, spin_fast}, 3'b100);
        finish_done(2'd1);
        chk("st_once", st_cnt - st_base, 1);
        chk("idle_unlock", door_lock, 0);

        // double wash
        start(1'b1);
        chk("dbl_latched", double_time, 1);
        adv(3'd2); adv(3'd3); adv(3'd2); adv(3'd3); adv(3'd4);
        chk("dbl_held", double_time, 1);
        adv(3'd5);
        finish_done(2'd2);
        chk("dbl_cleared", double_time, 0);

        // pause in wash; unpaused total would exceed the watchdog limit
        start(1'b0);
        adv(3'd2);
        repeat (10) cyc();
        pause_req = 1'b1;
        cyc();
        chk("pause_flag", timer_pause, 1);
        chk("pause_motor", motor_on, 0);
        repeat (44) cyc();
        chk("pause_phase", phase, 2);
        chk("pause_nofault", fault, 0);
        timer_finish = 1'b1;
        cyc();
        timer_finish = 1'b0;
        chk("pause_finish", phase, 3);
        chk("pause_motor_rinse", motor_on, 0);
        pause_req = 1'b0;
        cyc();
        chk("unpause_flag", timer_pause, 0);
        chk("unpause_motor", motor_on, 1);
        adv(3'd4); adv(3'd5);
        finish_done(2'd3);

        // stray coins in RINSE and on the DONE->IDLE edge
        start(1'b0);
        adv(3'd2); adv(3'd3);
        coin_in = 1'b1;
        cyc();
        chk("coin_rinse_phase", phase, 3);
        chk("coin_rinse_st", state_time, 0);
        coin_in = 1'b0;
        adv(3'd4); adv(3'd5);
        repeat (3) cyc();
        coin_in = 1'b1;
        cyc();
        chk("edge_coin_idle", phase, 0);
        chk("edge_coin_count", wash_count, 3);
        chk("edge_coin_st", state_time, 0);
        cyc();
        chk("edge_coin_nostart", {phase, state_time}, 4'b0000);
        coin_in = 1'b0;
        cyc();

        // saturation
        start(1'b0);
        adv(3'd2); adv(3'd3); adv(3'd4); adv(3'd5);
        finish_done(2'd3);

        // reset mid-cycle
        start(1'b0);
        adv(3'd2); adv(3'd3);
        rst = 1'b1;
        cyc();
        chk("midrst_phase", phase, 0);
        chk("midrst_count", wash_count, 0);
        chk("midrst_outs", {state_time, timer_pause, double_time, valve_on, motor_on,
                            spin_fast, door_lock, wash_done, fault}, 0);
        rst = 1'b0;
        cyc();

        // watchdog: 50 unpaused FILL cycles without a finish
        start(1'b0);
        repeat (48) cyc();
        chk("wd_pre", phase, 1);
        cyc();
        chk("wd_phase", phase, 7);
        chk("wd_outs", {fault, door_lock, valve_on, motor_on, spin_fast, timer_pause}, 6'b110001);
        coin_in = 1'b1;
        cyc(); cyc();
        chk("wd_coin", {phase, state_time}, 4'b1110);
        coin_in = 1'b0;
        timer_finish = 1'b1;
        cyc();
        timer_finish = 1'b0;
        chk("wd_finish_ign", phase, 7);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("wd_rst_phase", phase, 0);
        chk("wd_rst_outs", {state_time, timer_pause, double_time, valve_on, motor_on,
                            spin_fast, door_lock, wash_done, fault}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
